jedro_1_ifu: RTL

JEDRO_1_IFU -- requirements
Module: jedro_1_ifu

---
 rtl/jedro_1_ifu.sv | 107 ++++++++++
 1 files changed

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: single-outstanding ROM fetch into a prefetch FIFO
// feeding the decoder, with a one-cycle FLUSH on every redirect.
module jedro_1_ifu #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  imem_en_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
   input  logic                  jmp_valid_i,
   output logic [DATA_WIDTH-1:0] dec_instr_o,
   output logic [ADDR_WIDTH-1:0] dec_addr_o,
   output logic                  dec_valid_o,
   input  logic                  dec_ready_i
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic                  infl_q;
   logic [ADDR_WIDTH-1:0] infl_addr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [PW-1:0]         wr_ptr_q;
   logic [CW-1:0]         occ_q;
   logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];

   logic          issue;
   logic          push;
   logic          pop;
   logic [CW-1:0] occ_next;
   logic [CW-1:0] level_next;
   logic          unused_jmp_lsb;

   assign unused_jmp_lsb = ^jmp_addr_i[1:0];

   // Decoder handshake: an entry transfers on a cycle where dec_valid_o and
   // dec_ready_i are both high; while valid and not ready the head is held.
   assign dec_valid_o = (occ_q != '0);
   assign dec_instr_o = dec_valid_o ? fifo_instr[rd_ptr_q] : '0;
   assign dec_addr_o  = dec_valid_o ? fifo_addr[rd_ptr_q]  : '0;
   assign imem_en_o   = issue;
   assign imem_addr_o = pc_q;

   // Level counts FIFO entries plus the in-flight slot, so the FIFO can never overflow.
   always_comb begin
      push       = infl_q;
      pop        = dec_valid_o & dec_ready_i;
      occ_next   = occ_q + CW'(push) - CW'(pop);
      issue      = (state_q == RUN) && ((occ_q + CW'(infl_q)) < DEPTH);
      level_next = occ_next + CW'(issue);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= FLUSH;
         pc_q        <= BOOT_ADDR;
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         occ_q       <= '0;
      end else if (jmp_valid_i) begin
         state_q  <= FLUSH;
         pc_q     <= {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
         infl_q   <= 1'b0;
         rd_ptr_q <= wr_ptr_q;
         occ_q    <= '0;
      end else begin
         infl_q <= issue;
         if (issue) begin
            infl_addr_q <= pc_q;
            pc_q        <= pc_q + ADDR_WIDTH'(4);
         end
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         occ_q <= occ_next;
         case (state_q)
            FLUSH:   state_q <= RUN;
            default: state_q <= (level_next >= DEPTH) ? HOLD : RUN;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push && !jmp_valid_i) begin
         fifo_instr[wr_ptr_q] <= imem_rdata_i;
         fifo_addr[wr_ptr_q]  <= infl_addr_q;
      end
   end

endmodule
